// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Used by imem_loader and imem_checksum.
package imem_loader_pkg;

  localparam int unsigned DEPTH_DEF = 256;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

endpackage

// File: rtl/imem_checksum.sv
// Running mod-2^32 sum of the words written during one load.
// Only instantiated when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_checksum
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] sum_o
);

  logic [WORD_W-1:0] sum_q;
  logic [WORD_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Streams host words into the instruction memory and holds the CPU in reset.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds checksum_o.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_data_o,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              done_o
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum_o
`endif
);

  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     len_clamp;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                run_q, run_d;
  logic                xfer;
  logic                start_ok;
  logic                last;

  assign len_clamp = (len_i > DEPTH_L) ? DEPTH_L : len_i;
  assign xfer      = (state_q == LOAD) & wvalid_i;
  assign start_ok  = start_i & (state_q != LOAD);
  assign last      = (cnt_q == len_q - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    run_d   = run_q;
    unique case (1'b1)
      (state_q == LOAD): begin
        if (xfer) begin
          we_d   = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          data_d = wdata_i;
          cnt_d  = cnt_q + 1'b1;
          if (last) state_d = DONE;
        end
      end
      default: begin
        // release the CPU one cycle after entering DONE,
        // i.e. after the final write pulse has retired
        if (state_q == DONE) run_d = 1'b1;
        if (start_ok) begin
          len_d   = len_clamp;
          cnt_d   = '0;
          run_d   = 1'b0;
          state_d = (len_clamp == '0) ? DONE : LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      run_q   <= run_d;
    end
  end

  assign wready_o    = (state_q == LOAD);
  assign busy_o      = (state_q == LOAD);
  assign done_o      = (state_q == DONE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign cpu_rst_n_o = run_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  imem_checksum u_csum (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (start_ok),
    .add_i  (xfer),
    .data_i (wdata_i),
    .sum_o  (checksum_o)
  );
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
// Checksum steps run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW:0]   len_i;
  logic [31:0]   wdata_i;
  logic          wvalid_i;
  logic          wready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_data_o;
  logic          cpu_rst_n_o;
  logic          busy_o;
  logic          done_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum_o;
`endif

  wr_t           exp_q[$];
  int            total = 0;
  int            bad   = 0;
  int            nwr   = 0;
  int            w0;
  logic [AW-1:0] exp_addr;
  logic [AW-1:0] last_addr;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .wdata_i     (wdata_i),
    .wvalid_i    (wvalid_i),
    .wready_o    (wready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .cpu_rst_n_o (cpu_rst_n_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum_o  (checksum_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [AW:0] n);
    start_i  = 1'b1;
    len_i    = n;
    exp_addr = '0;
    @(negedge clk_i);
    start_i  = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    wdata_i  = d;
    wvalid_i = 1'b1;
    while (!wready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!wready_o) begin
      check("wready_timeout", wready_o, 1);
    end else begin
      exp_q.push_back({exp_addr, d});
      exp_addr++;
      @(negedge clk_i);
    end
  endtask

  // scoreboard: every write pulse must match the oldest accepted word
  always @(posedge clk_i) begin
    wr_t e;
    #1;
    if (mem_we_o) begin
      nwr++;
      last_addr = mem_addr_o;
      check("wr_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr_o, e.addr);
        check("wr_data", mem_data_o, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t2w[4];
    logic [31:0] t3w[3];
    t2w = '{32'h20080005, 32'h20090007,
            32'h01095020, 32'h00000000};
    t3w = '{32'h11111111, 32'h22222222,
            32'h33333333};
    rst_i    = 1'b1;
    start_i  = 1'b0;
    wvalid_i = 1'b0;
    len_i    = '0;
    wdata_i  = '0;
    exp_addr = '0;

    // 1: reset values
    #2;
    check("rst_wready", wready_o, 0);
    check("rst_we", mem_we_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", mem_data_o, 0);
    check("rst_cpu", cpu_rst_n_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("idle_busy", busy_o, 0);
    check("idle_done", done_o, 0);
    check("idle_cpu", cpu_rst_n_o, 0);
    check("idle_nwr", nwr, 0);

    // 2: four words back-to-back
    w0 = nwr;
    start(4);
    check("t2_busy", busy_o, 1);
    foreach (t2w[i]) send(t2w[i]);
    wvalid_i = 1'b0;
    check("t2_done", done_o, 1);
    check("t2_lastwe", mem_we_o, 1);
    check("t2_lastaddr", mem_addr_o, 3);
    check("t2_cpu_hold", cpu_rst_n_o, 0);
    check("t2_wready", wready_o, 0);
    @(negedge clk_i);
    check("t2_cpu_rel", cpu_rst_n_o, 1);
    check("t2_we_off", mem_we_o, 0);
    check("t2_nwr", nwr - w0, 4);

    // 3: reload with stalls; start during LOAD ignored
    w0 = nwr;
    start(3);
    check("t3_done0", done_o, 0);
    check("t3_cpu0", cpu_rst_n_o, 0);
    check("t3_busy", busy_o, 1);
    for (int i = 0; i < 3; i++) begin
      send(t3w[i]);
      wvalid_i = 1'b0;
      if (i < 2) begin
        start_i = (i == 0);
        len_i   = 1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_i);
          start_i = 1'b0;
          check("t3_stall_busy", busy_o, 1);
        end
      end
    end
    check("t3_done", done_o, 1);
    check("t3_nwr", nwr - w0, 3);

    // 4: zero length, then oversize length
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    w0 = nwr;
    start(0);
    check("t4_zero_done", done_o, 1);
    check("t4_zero_busy", busy_o, 0);
    @(negedge clk_i);
    check("t4_zero_cpu", cpu_rst_n_o, 1);
    check("t4_zero_nwr", nwr - w0, 0);
    w0 = nwr;
    start(DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) begin
      send((i * 32'h01010101) ^ 32'hA5A50000);
    end
    wdata_i = 32'hDEADBEEF;
    check("t4_big_done", done_o, 1);
    check("t4_big_wready", wready_o, 0);
    repeat (3) @(negedge clk_i);
    wvalid_i = 1'b0;
    check("t4_big_nwr", nwr - w0, DEPTH);
    check("t4_big_last", last_addr, DEPTH - 1);
    check("t4_big_cpu", cpu_rst_n_o, 1);

    // 5: reset in the middle of a load
    w0 = nwr;
    start(6);
    send(32'hCAFE0001);
    send(32'hCAFE0002);
    wvalid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check("t5_we", mem_we_o, 0);
    check("t5_addr", mem_addr_o, 0);
    check("t5_data", mem_data_o, 0);
    check("t5_cpu", cpu_rst_n_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_done", done_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t5_nwr_pre", nwr - w0, 2);
    check("t5_cpu_idle", cpu_rst_n_o, 0);
    w0 = nwr;
    start(2);
    send(32'hBEEF0001);
    send(32'hBEEF0002);
    wvalid_i = 1'b0;
    check("t5_done2", done_o, 1);
    check("t5_last", last_addr, 1);
    check("t5_nwr", nwr - w0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: checksum wrap and clear on reload
    start(2);
    check("t6_clr", checksum_o, 0);
    send(32'hFFFFFFFF);
    send(32'h00000002);
    wvalid_i = 1'b0;
    check("t6_sum", checksum_o, 32'h1);
    @(negedge clk_i);
    check("t6_hold", checksum_o, 32'h1);
    start(1);
    check("t6_clr2", checksum_o, 0);
    send(32'h00000010);
    wvalid_i = 1'b0;
    check("t6_sum2", checksum_o, 32'h10);
`endif

    @(negedge clk_i);
    check("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
